// File: rtl/if_stage.sv
// if_stage: instruction fetch stage that owns the PC, fetches words from imem and buffers them with their PCs for decode
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       in-order word fetch requests
//   imem_rsp_valid/data             in-order responses, one per accepted request
//   redirect_en/redirect_pc         control-flow redirect from execute
//   id_valid/ready, id_inst/pc/pc4  instruction bundle handed to decode
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_out, r_cnt, r_drop;
    logic [AW-1:0] r_tag_wr, r_tag_rd, r_wr, r_rd;
    logic [31:0]   r_tag  [DEPTH];
    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_ipc  [DEPTH];

    logic          w_can_req, w_req, w_rsp, w_pop;
    logic [CW:0]   w_used;
    logic [CW-1:0] w_drop_nx;

    // credits count both in-flight requests and buffered instructions, so the FIFO can never overflow
    assign w_used         = {1'b0, r_out} + {1'b0, r_cnt};
    assign w_can_req      = (r_state == RUN) && !redirect_en && (w_used < LIMIT);
    // state reads RUN while reset is held, so the request is gated by rst directly
    assign imem_req_valid = !rst && w_can_req;
    assign imem_req_addr  = r_pc;
    assign w_req          = w_can_req && imem_req_ready;
    assign w_rsp          = imem_rsp_valid && (r_state == RUN);
    assign id_valid       = (r_cnt != '0);
    assign w_pop          = id_valid && id_ready;
    // every response still owed becomes a drop; a response arriving in the redirect cycle is itself dropped
    assign w_drop_nx      = r_drop + r_out - CW'(imem_rsp_valid);
    // an empty FIFO presents zeros so reset and redirect leave clean outputs
    assign id_inst        = id_valid ? r_inst[r_rd] : 32'h0;
    assign id_pc          = id_valid ? r_ipc[r_rd] : 32'h0;
    assign id_pc4         = id_valid ? r_ipc[r_rd] + 32'd4 : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_out    <= '0;
            r_cnt    <= '0;
            r_drop   <= '0;
            r_tag_wr <= '0;
            r_tag_rd <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
        end else if (redirect_en) begin
            r_pc     <= redirect_pc & ~32'd3;
            r_out    <= '0;
            r_cnt    <= '0;
            r_drop   <= w_drop_nx;
            r_state  <= (w_drop_nx != '0) ? FLUSH : RUN;
            r_tag_wr <= '0;
            r_tag_rd <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
        end else begin
            if (w_req) begin
                r_pc     <= r_pc + 32'd4;
                r_tag_wr <= r_tag_wr + 1'b1;
            end
            if (w_rsp) begin
                r_tag_rd <= r_tag_rd + 1'b1;
                r_wr     <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_out <= r_out + CW'(w_req) - CW'(w_rsp);
            r_cnt <= r_cnt + CW'(w_rsp) - CW'(w_pop);
            if (r_state == FLUSH && imem_rsp_valid) begin
                r_drop  <= r_drop - 1'b1;
                r_state <= (r_drop == CW'(1)) ? RUN : FLUSH;
            end
        end
    end

    // storage needs no reset: occupancy is tracked by the counters above
    always_ff @(posedge clk) begin
        if (w_req)
            r_tag[r_tag_wr] <= r_pc;
        if (w_rsp) begin
            r_inst[r_wr] <= imem_rsp_data;
            r_ipc[r_wr]  <= r_tag[r_tag_rd];
        end
    end
endmodule
